unidade_busca: RTL and testbench
================================

# unidade_busca

Instruction fetch stage that sits directly upstream of the control unit: it owns the program counter, drives the instruction-memory address, latches the fetched word into the instruction register and presents its `opcode`/`opex` fields to decode. It consumes the jump/branch/call/return indications decoded from the instruction it is currently presenting. It keeps a hardware return-address stack for call/return, and squashes the one wrong-path fetch on every taken transfer.

## Interface
- `ADDR_W`, 10: instruction address width, in words.
- `STACK_DEPTH`, 8: return-stack entries; must be a power of two and at least 2.
- `RESET_PC`, 0: PC value after reset.
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high; dominates every other input.
- `stall`  in  1: hold all state, PC, IR and stack unchanged.
- `imem_addr`  out  ADDR_W: equals `pc`, combinational from the register.
- `imem_data`  in  32: instruction word at `imem_addr`, valid in the same cycle (asynchronous ROM).
- `instr`  out  32: registered instruction register (IR).
- `opcode`  out  6: `instr[31:26]`.
- `opex`  out  6: `instr[5:0]`.
- `ir_pc`  out  ADDR_W: address the IR was fetched from.
- `ir_valid`  out  1: IR holds a real instruction; 0 means bubble, and downstream gates all writes with it.
- `jump`  in  1: unconditional transfer to `target`.
- `branch`  in  1: conditional transfer, taken when `cond`=1.
- `cond`  in  1: branch condition from the ALU.
- `push`  in  1: together with `jump`, call: push `ir_pc+1`.
- `pop`  in  1: return: transfer to top of stack.
- `target`  in  ADDR_W: absolute jump target.
- `offset`  in  16: signed branch offset, in words.
- `sp`  out  $clog2(STACK_DEPTH)+1: current stack occupancy, 0..STACK_DEPTH.
- `stack_err`  out  1: sticky flag for overflow or underflow; cleared only by reset.

## Operation
- Control inputs act only when `ir_valid`=1 and `stall`=0. Otherwise they are ignored.
- Priority is `pop` > `jump` > `branch`. `push` without `jump` is ignored. `push` and `pop` together is a pop only.
- Next-PC selection:
  - Pop with `sp`>0: `pc <= stack[sp-1]`, `sp` decrements.
  - Jump: `pc <= target`. If `push`, write `ir_pc+1` at `stack[sp]` and increment `sp`.
  - Branch with `cond`=1: `pc <= ir_pc + 1 + sext(offset)`, truncated to ADDR_W.
  - Otherwise: `pc <= pc+1`.
- All PC arithmetic wraps modulo 2^ADDR_W.
- Taken transfer (pop with non-empty stack, jump, or taken branch): `instr <= 0`, `ir_valid <= 0`, `ir_pc <= 0`. This squashes the word fetched at the old `pc`.
- No transfer: `instr <= imem_data`, `ir_pc <= pc`, `ir_valid <= 1`.
- Push when `sp`=STACK_DEPTH: the jump still happens, the push is discarded, `sp` is unchanged and `stack_err` is set.
- Pop when `sp`=0: no transfer and sequential flow continues (no squash), and `stack_err` is set.
- Stall: every register holds, including `stack_err`. A transfer held in the IR executes on the first non-stalled cycle.

## Timing
- Reset values:
  - `pc`=RESET_PC
  - `instr`=0, `ir_pc`=0, `ir_valid`=0
  - `sp`=0, `stack_err`=0
  - Stack contents are don't-care.
- The first valid instruction, at RESET_PC, appears in the IR one cycle after `reset` deasserts.
- Fetch-to-IR latency is 1 cycle. Sequential throughput is one instruction per cycle.
- A taken transfer costs exactly 1 bubble cycle. The target instruction appears in the IR 2 cycles after the transfer instruction first appears.
- Reset asserted mid-stall or during a transfer wins at that edge. No pending transfer survives reset.
- `opcode`, `opex` and `imem_addr` are purely combinational from registers. There is no input-to-output combinational path.

## Test plan
- Reset, then sequential fetch with ROM[i]=i: `ir_pc` follows 0,1,2,3 and `ir_valid`=1 from the 2nd cycle after reset deasserts.
- `jump` with `target`=0x20 while `ir_pc`=5: the next cycle has `ir_valid`=0, the following cycle has `ir_pc`=0x20, and `sp` stays at 0.
- Branch at `ir_pc`=0x10 with `offset`=-3 and `cond`=1: the target is 0x0E after a 1 bubble. With `cond`=0: `ir_pc`=0x11 next with no bubble.
- Call at 0x08 then return: `sp` goes 0→1→0 and execution resumes at `ir_pc`=0x09. Nine nested calls with depth 8: the 9th sets `stack_err` and `sp` stays at 8.
- `pop` with `sp`=0 at `ir_pc`=3: `stack_err`=1, the next `ir_pc` is 4 and there is no bubble.
- `stall` held 3 cycles over a pending jump: `pc`, `instr` and `sp` are frozen, and the jump executes on the cycle after release. Reset asserted during the stall gives `pc`=RESET_PC and `ir_valid`=0.

Source files
------------

// File: rtl/unidade_busca.sv
`default_nettype none
// ============================================================================
// Module      : unidade_busca
// Description : Instruction fetch stage. Owns the PC, drives the instruction
//               ROM address, latches the fetched word into the IR and keeps
//               a hardware return-address stack for call/return. Every taken
//               transfer squashes the single wrong-path fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module unidade_busca #(
    parameter int ADDR_W      = 10,
    parameter int STACK_DEPTH = 8,
    parameter int RESET_PC    = 0
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           stall,
    output logic [ADDR_W-1:0]              imem_addr,
    input  logic [31:0]                    imem_data,
    output logic [31:0]                    instr,
    output logic [5:0]                     opcode,
    output logic [5:0]                     opex,
    output logic [ADDR_W-1:0]              ir_pc,
    output logic                           ir_valid,
    input  logic                           jump,
    input  logic                           branch,
    input  logic                           cond,
    input  logic                           push,
    input  logic                           pop,
    input  logic [ADDR_W-1:0]              target,
    input  logic [15:0]                    offset,
    output logic [$clog2(STACK_DEPTH):0]   sp,
    output logic                           stack_err
);

    localparam int                c_PTR_W    = $clog2(STACK_DEPTH);
    localparam int                c_SP_W     = c_PTR_W + 1;
    localparam logic [ADDR_W-1:0] c_RESET_PC = ADDR_W'(RESET_PC);
    localparam logic [c_SP_W-1:0] c_SP_FULL  = c_SP_W'(STACK_DEPTH);

    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_ir_pc;
    logic              r_ir_valid;
    logic [c_SP_W-1:0] r_sp;
    logic              r_stack_err;
    logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

    logic              w_act;
    logic              w_do_pop;
    logic              w_pop_ok;
    logic              w_pop_err;
    logic              w_do_jump;
    logic              w_push_ok;
    logic              w_push_err;
    logic              w_do_br;
    logic              w_taken;
    logic [c_SP_W-1:0] w_sp_dec;
    logic [c_PTR_W-1:0] w_top_idx;
    logic [c_PTR_W-1:0] w_push_idx;
    logic [ADDR_W-1:0] w_ret_addr;
    logic [ADDR_W-1:0] w_off_ext;
    logic [ADDR_W-1:0] w_br_target;
    logic [ADDR_W-1:0] w_next_pc;

    assign imem_addr = r_pc;
    assign instr     = r_instr;
    assign opcode    = r_instr[31:26];
    assign opex      = r_instr[5:0];
    assign ir_pc     = r_ir_pc;
    assign ir_valid  = r_ir_valid;
    assign sp        = r_sp;
    assign stack_err = r_stack_err;

    // Decoded controls only count for a real instruction in a non-stalled cycle
    assign w_act      = r_ir_valid & ~stall;
    assign w_do_pop   = w_act & pop;
    assign w_pop_ok   = w_do_pop & (r_sp != '0);
    assign w_pop_err  = w_do_pop & (r_sp == '0);
    assign w_do_jump  = w_act & ~pop & jump;
    assign w_push_ok  = w_do_jump & push & (r_sp != c_SP_FULL);
    assign w_push_err = w_do_jump & push & (r_sp == c_SP_FULL);
    assign w_do_br    = w_act & ~pop & ~jump & branch & cond;
    // An empty-stack pop is not a transfer: flow continues sequentially
    assign w_taken    = w_pop_ok | w_do_jump | w_do_br;

    assign w_sp_dec    = r_sp - c_SP_W'(1);
    assign w_top_idx   = w_sp_dec[c_PTR_W-1:0];
    assign w_push_idx  = r_sp[c_PTR_W-1:0];
    assign w_ret_addr  = r_ir_pc + ADDR_W'(1);
    assign w_off_ext   = ADDR_W'($signed(offset));
    assign w_br_target = w_ret_addr + w_off_ext;

    // Next-PC selection: pop > jump > taken branch > sequential
    always_comb begin
        w_next_pc = r_pc + ADDR_W'(1);
        if (w_pop_ok) begin
            w_next_pc = r_stack[w_top_idx];
        end else if (w_do_jump) begin
            w_next_pc = target;
        end else if (w_do_br) begin
            w_next_pc = w_br_target;
        end
    end

    // PC, IR, stack pointer and error flag; stall freezes all of them
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc        <= c_RESET_PC;
            r_instr     <= '0;
            r_ir_pc     <= '0;
            r_ir_valid  <= 1'b0;
            r_sp        <= '0;
            r_stack_err <= 1'b0;
        end else if (!stall) begin
            r_pc <= w_next_pc;
            if (w_taken) begin
                r_instr    <= '0;
                r_ir_pc    <= '0;
                r_ir_valid <= 1'b0;
            end else begin
                r_instr    <= imem_data;
                r_ir_pc    <= r_pc;
                r_ir_valid <= 1'b1;
            end
            if (w_pop_ok) begin
                r_sp <= w_sp_dec;
            end else if (w_push_ok) begin
                r_sp <= r_sp + c_SP_W'(1);
            end
            if (w_pop_err || w_push_err) begin
                r_stack_err <= 1'b1;
            end
        end
    end

    // Return-address storage; contents need no reset
    always_ff @(posedge clock) begin
        if (!reset && w_push_ok) begin
            r_stack[w_push_idx] <= w_ret_addr;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_unidade_busca.sv
`default_nettype none
// ============================================================================
// Module      : tb_unidade_busca
// Description : Self-checking bench for unidade_busca: directed vector table,
//               hand-written call/stall/reset sequences and randomized
//               stimulus against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unidade_busca;

    logic        clock = 1'b0;
    logic        reset, stall, jump, branch, cond, push, pop;
    logic [9:0]  target;
    logic [15:0] offset;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [5:0]  opcode, opex;
    logic [9:0]  ir_pc;
    logic        ir_valid;
    logic [3:0]  sp;
    logic        stack_err;

    logic [31:0] rom [0:1023];
    assign imem_data = rom[imem_addr];

    always #5 clock = ~clock;

    unidade_busca #(.ADDR_W(10), .STACK_DEPTH(8), .RESET_PC(0)) dut (
        .clock(clock), .reset(reset), .stall(stall),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .instr(instr), .opcode(opcode), .opex(opex),
        .ir_pc(ir_pc), .ir_valid(ir_valid),
        .jump(jump), .branch(branch), .cond(cond), .push(push), .pop(pop),
        .target(target), .offset(offset),
        .sp(sp), .stack_err(stack_err)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [9:0]  m_pc    = 10'd0;
    logic [31:0] m_instr = 32'd0;
    logic [9:0]  m_irpc  = 10'd0;
    logic        m_valid = 1'b0;
    logic        m_err   = 1'b0;
    logic [9:0]  m_stack [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: model evaluates the current inputs, then DUT is compared
    task automatic cycle();
        logic [9:0]  npc;
        logic [31:0] ninstr;
        logic [9:0]  nirpc;
        logic        nvalid;
        logic        taken;
        int          t;
        npc = m_pc; ninstr = m_instr; nirpc = m_irpc; nvalid = m_valid;
        if (reset) begin
            npc = 10'd0; ninstr = 0; nirpc = 0; nvalid = 0;
            m_stack.delete();
            m_err = 0;
        end else if (!stall) begin
            taken = 0;
            npc = m_pc + 10'd1;
            if (m_valid) begin
                if (pop) begin
                    if (m_stack.size() > 0) begin
                        npc = m_stack.pop_back();
                        taken = 1;
                    end else begin
                        m_err = 1;
                    end
                end else if (jump) begin
                    npc = target;
                    taken = 1;
                    if (push) begin
                        if (m_stack.size() < 8) m_stack.push_back(m_irpc + 10'd1);
                        else m_err = 1;
                    end
                end else if (branch && cond) begin
                    t = int'(m_irpc) + 1 + int'($signed(offset));
                    npc = 10'(t);
                    taken = 1;
                end
            end
            if (taken) begin
                ninstr = 0; nirpc = 0; nvalid = 0;
            end else begin
                ninstr = rom[m_pc]; nirpc = m_pc; nvalid = 1;
            end
        end
        @(posedge clock);
        #1;
        m_pc = npc; m_instr = ninstr; m_irpc = nirpc; m_valid = nvalid;
        chk("imem_addr", 32'(imem_addr), 32'(m_pc));
        chk("instr",     instr, m_instr);
        chk("opcode",    32'(opcode), 32'(m_instr[31:26]));
        chk("opex",      32'(opex), 32'(m_instr[5:0]));
        chk("ir_pc",     32'(ir_pc), 32'(m_irpc));
        chk("ir_valid",  32'(ir_valid), 32'(m_valid));
        chk("sp",        32'(sp), 32'(m_stack.size()));
        chk("stack_err", 32'(stack_err), 32'(m_err));
    endtask

    task automatic idle_inputs();
        reset = 0; stall = 0; jump = 0; branch = 0; cond = 0; push = 0; pop = 0;
        target = 0; offset = 0;
    endtask

    typedef struct {
        logic        rst, jmp, br, cnd, psh, pp;
        logic [9:0]  tgt;
        logic [15:0] off;
        logic        ev;
        logic [9:0]  eirpc;
        logic [3:0]  esp;
        logic        eerr;
    } vec_t;

    function automatic vec_t mk(logic rst, logic jmp, logic br, logic cnd, logic psh, logic pp,
                                logic [9:0] tgt, logic [15:0] off,
                                logic ev, logic [9:0] eirpc, logic [3:0] esp, logic eerr);
        vec_t v;
        v.rst = rst; v.jmp = jmp; v.br = br; v.cnd = cnd; v.psh = psh; v.pp = pp;
        v.tgt = tgt; v.off = off; v.ev = ev; v.eirpc = eirpc; v.esp = esp; v.eerr = eerr;
        return v;
    endfunction

    vec_t vecs [31];

    initial begin
        idle_inputs();
        reset = 1;
        for (int i = 0; i < 1024; i++) rom[i] = 32'(i);

        //            rst jmp br cnd psh pop  tgt      off      ev irpc    sp err
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 10'h000, 16'h0000, 0, 10'h000, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 10'h000, 16'h0000, 1, 10'h000, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 10'h000, 16'h0000, 1, 10'h001, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 10'h000, 16'h0000, 1, 10'h002, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 10'h000, 16'h0000, 1, 10'h003, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 10'h000, 16'h0000, 1, 10'h004, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 10'h000, 16'h0000, 1, 10'h005, 0, 0);
        vecs[7]  = mk(0, 1, 0, 0, 0, 0, 10'h020, 16'h0000, 0, 10'h000, 0, 0);
        vecs[8]  = mk(0, 1, 0, 0, 0, 0, 10'h3FF, 16'h0000, 1, 10'h020, 0, 0);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 10'h000, 16'h0000, 1, 10'h021, 0, 0);
        vecs[10] = mk(0, 1, 0, 0, 0, 0, 10'h010, 16'h0000, 0, 10'h000, 0, 0);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 10'h000, 16'h0000, 1, 10'h010, 0, 0);
        vecs[12] = mk(0, 0, 1, 1, 0, 0, 10'h000, 16'hFFFD, 0, 10'h000, 0, 0);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 10'h000, 16'h0000, 1, 10'h00E, 0, 0);
        vecs[14] = mk(0, 1, 0, 0, 0, 0, 10'h010, 16'h0000, 0, 10'h000, 0, 0);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 10'h000, 16'h0000, 1, 10'h010, 0, 0);
        vecs[16] = mk(0, 0, 1, 0, 0, 0, 10'h000, 16'hFFFD, 1, 10'h011, 0, 0);
        vecs[17] = mk(0, 1, 0, 0, 0, 0, 10'h008, 16'h0000, 0, 10'h000, 0, 0);
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 10'h000, 16'h0000, 1, 10'h008, 0, 0);
        vecs[19] = mk(0, 1, 0, 0, 1, 0, 10'h040, 16'h0000, 0, 10'h000, 1, 0);
        vecs[20] = mk(0, 0, 0, 0, 0, 0, 10'h000, 16'h0000, 1, 10'h040, 1, 0);
        vecs[21] = mk(0, 0, 0, 0, 0, 1, 10'h000, 16'h0000, 0, 10'h000, 0, 0);
        vecs[22] = mk(0, 0, 0, 0, 0, 0, 10'h000, 16'h0000, 1, 10'h009, 0, 0);
        vecs[23] = mk(0, 1, 0, 0, 0, 0, 10'h003, 16'h0000, 0, 10'h000, 0, 0);
        vecs[24] = mk(0, 0, 0, 0, 0, 0, 10'h000, 16'h0000, 1, 10'h003, 0, 0);
        vecs[25] = mk(0, 0, 0, 0, 0, 1, 10'h000, 16'h0000, 1, 10'h004, 0, 1);
        vecs[26] = mk(0, 1, 0, 0, 0, 0, 10'h3FF, 16'h0000, 0, 10'h000, 0, 1);
        vecs[27] = mk(0, 0, 0, 0, 0, 0, 10'h000, 16'h0000, 1, 10'h3FF, 0, 1);
        vecs[28] = mk(0, 0, 0, 0, 0, 0, 10'h000, 16'h0000, 1, 10'h000, 0, 1);
        vecs[29] = mk(0, 0, 1, 1, 0, 0, 10'h000, 16'hFFFF, 0, 10'h000, 0, 1);
        vecs[30] = mk(0, 0, 0, 0, 0, 0, 10'h000, 16'h0000, 1, 10'h000, 0, 1);

        // Directed vector table (ROM[i] = i)
        for (int i = 0; i < 31; i++) begin
            reset = vecs[i].rst; jump = vecs[i].jmp; branch = vecs[i].br; cond = vecs[i].cnd;
            push = vecs[i].psh; pop = vecs[i].pp; target = vecs[i].tgt; offset = vecs[i].off;
            stall = 0;
            cycle();
            chk($sformatf("vec%0d.ir_valid", i), 32'(ir_valid), 32'(vecs[i].ev));
            chk($sformatf("vec%0d.ir_pc", i), 32'(ir_pc), 32'(vecs[i].eirpc));
            chk($sformatf("vec%0d.instr", i), instr, vecs[i].ev ? 32'(vecs[i].eirpc) : 32'd0);
            chk($sformatf("vec%0d.sp", i), 32'(sp), 32'(vecs[i].esp));
            chk($sformatf("vec%0d.stack_err", i), 32'(stack_err), 32'(vecs[i].eerr));
        end

        // Nine nested calls into an 8-deep stack, then unwind
        idle_inputs(); reset = 1; cycle();
        reset = 0; cycle();
        for (int k = 0; k < 9; k++) begin
            jump = 1; push = 1; target = 10'(10'h100 + k * 8);
            cycle();
            jump = 0; push = 0;
            cycle();
            if (k == 7) chk("nest8.stack_err", 32'(stack_err), 32'd0);
        end
        chk("nest9.sp", 32'(sp), 32'd8);
        chk("nest9.stack_err", 32'(stack_err), 32'd1);
        for (int k = 0; k < 8; k++) begin
            pop = 1; cycle();
            pop = 0; cycle();
        end
        chk("unwind.sp", 32'(sp), 32'd0);
        chk("unwind.ir_pc", 32'(ir_pc), 32'd1);

        // Stall held over a pending call, then reset during a stall
        idle_inputs(); reset = 1; cycle();
        reset = 0; cycle(); cycle();
        jump = 1; push = 1; target = 10'h055; stall = 1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("stall.imem_addr", 32'(imem_addr), 32'd2);
            chk("stall.instr", instr, 32'd1);
            chk("stall.sp", 32'(sp), 32'd0);
        end
        stall = 0; cycle();
        chk("release.ir_valid", 32'(ir_valid), 32'd0);
        chk("release.sp", 32'(sp), 32'd1);
        jump = 0; push = 0; cycle();
        chk("release.ir_pc", 32'(ir_pc), 32'h055);
        stall = 1; jump = 1; target = 10'h077; cycle();
        reset = 1; cycle();
        chk("rst_stall.imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_stall.ir_valid", 32'(ir_valid), 32'd0);
        chk("rst_stall.sp", 32'(sp), 32'd0);

        // Randomized stimulus against the reference model
        for (int i = 0; i < 1024; i++) rom[i] = $urandom;
        idle_inputs(); reset = 1; cycle();
        for (int n = 0; n < 3000; n++) begin
            reset  = ($urandom_range(0, 199) == 0);
            stall  = ($urandom_range(0, 4) == 0);
            jump   = ($urandom_range(0, 5) == 0);
            branch = ($urandom_range(0, 4) == 0);
            cond   = $urandom_range(0, 1) == 1;
            push   = $urandom_range(0, 1) == 1;
            pop    = ($urandom_range(0, 6) == 0);
            target = 10'($urandom);
            offset = 16'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
